// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output-side datapath: lane/word geometry,
// the unpack reader FSM states and the lane extraction helper.
package cnn_pkg;

    localparam int CNN_DATA_W = 16;
    localparam int CNN_WORD_W = 64;
    localparam int CNN_LANES  = CNN_WORD_W / CNN_DATA_W;

    typedef logic [CNN_DATA_W-1:0] lane_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_PRIME,
        RD_STREAM,
        RD_FLUSH,
        RD_FIN
    } rd_state_e;

    // Lane 0 is the most significant 16 bits of the packed word.
    function automatic lane_t lane_of(input logic [CNN_WORD_W-1:0] word, input logic [1:0] idx);
        lane_t lane;
        lane = word[CNN_WORD_W-1 -: CNN_DATA_W];
        case (idx)
            2'd0:    lane = word[4*CNN_DATA_W-1 -: CNN_DATA_W];
            2'd1:    lane = word[3*CNN_DATA_W-1 -: CNN_DATA_W];
            2'd2:    lane = word[2*CNN_DATA_W-1 -: CNN_DATA_W];
            default: lane = word[CNN_DATA_W-1 -: CNN_DATA_W];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/ofm_word_fifo.sv
// Two-entry word buffer (holding + prefetch). Head entry is always visible
// on dout_o; push and pop may happen on the same edge.
module ofm_word_fifo
    import cnn_pkg::*;
#(
    parameter int WORD_W = CNN_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] din_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);

    logic [WORD_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Occupancy after this edge's push/pop.
    always_comb begin
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    // Word storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ofm_unpack_reader.sv
// Drains a run of packed 64-bit psum words from the output RAM and streams
// them as 16-bit lanes (MSB lane first) on a valid/ready port.
// Optional build macro OFM_RELU_EN: negative lanes are forced to zero on the
// output mux.
module ofm_unpack_reader
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WORD_W = CNN_WORD_W,
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    output logic              busy,
    output logic              done,
    output logic              ram_ena,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int         LANES     = WORD_W / DATA_W;
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    rd_state_e         state_q;
    logic              busy_q;
    logic              done_q;
    logic              ram_ena_q;
    logic              pend_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] rd_left_q;
    logic [ADDR_W-1:0] emit_left_q;
    logic [1:0]        lane_q;

    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic              issue;
    logic              xfer;
    logic              pop;
    lane_t             lane_raw;
    lane_t             lane_out;

    ofm_word_fifo #(
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pend_q),
        .din_i   (ram_dout),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A read issued now lands two edges later; count words already buffered
    // plus both in-flight slots so the buffer can never be overrun.
    assign occ   = 3'(fifo_count) + 3'(pend_q) + 3'(ram_ena_q);
    assign issue = ((state_q == RD_PRIME) || (state_q == RD_STREAM)) &&
                   (rd_left_q != '0) && !fifo_full && (occ < 3'd2);

    assign out_valid = !fifo_empty;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (lane_q == LAST_LANE);
    assign out_last  = out_valid && (lane_q == LAST_LANE) && (emit_left_q == ADDR_W'(1));

    // Lane select with optional rectification; zero whenever nothing is valid.
    always_comb begin
        lane_raw = lane_of(head, lane_q);
`ifdef OFM_RELU_EN
        lane_out = lane_raw[CNN_DATA_W-1] ? '0 : lane_raw;
`else
        lane_out = lane_raw;
`endif
        out_data = out_valid ? DATA_W'(lane_out) : '0;
    end

    // Reader FSM with read-issue, address, lane and word bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_ena_q   <= 1'b0;
            pend_q      <= 1'b0;
            ram_addr_q  <= '0;
            rd_left_q   <= '0;
            emit_left_q <= '0;
            lane_q      <= 2'd0;
        end else begin
            done_q    <= 1'b0;
            ram_ena_q <= 1'b0;
            pend_q    <= ram_ena_q;
            if (xfer) lane_q <= lane_q + 2'd1;
            if (pop)  emit_left_q <= emit_left_q - ADDR_W'(1);
            case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        if (word_cnt == '0) begin
                            state_q <= RD_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= RD_PRIME;
                            busy_q      <= 1'b1;
                            ram_ena_q   <= 1'b1;
                            ram_addr_q  <= base_addr;
                            rd_left_q   <= word_cnt - ADDR_W'(1);
                            emit_left_q <= word_cnt;
                            lane_q      <= 2'd0;
                        end
                    end
                end
                RD_PRIME, RD_STREAM: begin
                    if (issue) begin
                        ram_ena_q  <= 1'b1;
                        ram_addr_q <= ram_addr_q + ADDR_W'(1);
                        rd_left_q  <= rd_left_q - ADDR_W'(1);
                    end
                    state_q <= ((rd_left_q == '0) || (issue && (rd_left_q == ADDR_W'(1))))
                               ? RD_FLUSH : RD_STREAM;
                end
                RD_FLUSH: begin
                    if (pop && (emit_left_q == ADDR_W'(1))) begin
                        state_q <= RD_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                RD_FIN: begin
                    state_q <= RD_IDLE;
                end
                default: begin
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_ena  = ram_ena_q;
    assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_ofm_unpack_reader.sv
// Self-checking bench for ofm_unpack_reader: directed runs plus randomized
// runs against a queue-based lane/address model built from RAM contents.
module tb_ofm_unpack_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        ram_ena;
    logic [15:0] ram_addr;
    logic [63:0] ram_dout;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [63:0] ram_mem [65536];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_lanes [$];
    logic [15:0] exp_addrs [$];
    int          cyc;
    int          n_xfer, n_ena, n_done;
    int          first_v, last_x, done_c;
    int          mode_g;
    int          junk_at;
    bit          stalled;
    logic [15:0] held_data;
    logic        held_last;

    ofm_unpack_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .ram_ena   (ram_ena),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle latency.
    always @(posedge clk) begin
        if (ram_ena) ram_dout <= ram_mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] relu_ref(input logic [15:0] v);
`ifdef OFM_RELU_EN
        return (v >= 16'h8000) ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic bit rdy_of(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Observe one cycle (called at the falling edge).
    task automatic sample();
        logic [15:0] e;
        if (ram_ena) begin
            n_ena++;
            if (exp_addrs.size() == 0) check_val("extra_read", 64'(1), 64'(0));
            else begin
                e = exp_addrs.pop_front();
                check_val("ram_addr", 64'(ram_addr), 64'(e));
            end
        end
        if (stalled) begin
            check_val("hold_valid", 64'(out_valid), 64'(1));
            check_val("hold_data", 64'(out_data), 64'(held_data));
            check_val("hold_last", 64'(out_last), 64'(held_last));
        end
        stalled = 1'b0;
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && out_ready) begin
            if (exp_lanes.size() == 0) check_val("extra_lane", 64'(1), 64'(0));
            else begin
                e = exp_lanes.pop_front();
                check_val("lane", 64'(out_data), 64'(e));
                check_val("last", 64'(out_last), 64'(exp_lanes.size() == 0));
            end
            n_xfer++;
            last_x = cyc;
        end else if (out_valid) begin
            stalled   = 1'b1;
            held_data = out_data;
            held_last = out_last;
        end
        if (done) begin
            n_done++;
            done_c = cyc;
            check_val("busy_at_done", 64'(busy), 64'(0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        out_ready = rdy_of(mode_g, cyc);
        start     = (junk_at >= 0) && (cyc == junk_at);
        if (start) begin
            base_addr = 16'($urandom);
            word_cnt  = 16'($urandom_range(1, 9));
        end
        @(negedge clk);
        sample();
    endtask

    task automatic run(input logic [15:0] base, input logic [15:0] cnt, input int mode, input int abort_after);
        logic [15:0] a;
        logic [63:0] wd;
        exp_lanes.delete();
        exp_addrs.delete();
        for (int w = 0; w < int'(cnt); w++) begin
            a  = base + 16'(w);
            wd = ram_mem[a];
            exp_addrs.push_back(a);
            for (int l = 0; l < 4; l++) exp_lanes.push_back(relu_ref(wd[63-16*l -: 16]));
        end
        n_xfer = 0; n_ena = 0; n_done = 0;
        first_v = -1; last_x = -1; done_c = -1;
        stalled = 1'b0;
        mode_g  = mode;
        @(posedge clk);
        #1;
        base_addr = base;
        word_cnt  = cnt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        cyc       = 0;
        start     = 1'b0;
        base_addr = 16'($urandom);
        word_cnt  = 16'($urandom);
        out_ready = rdy_of(mode, 0);
        @(negedge clk);
        sample();
        check_val("busy_after_start", 64'(busy), 64'(cnt != 0));
        while (n_done == 0 && cyc < 400 && !(abort_after > 0 && n_xfer >= abort_after)) step();
        if (abort_after > 0) return;
        if (n_done == 0) check_val("done_timeout", 64'(0), 64'(1));
        junk_at = -1;
        step();
        step();
        check_val("xfer_count", 64'(n_xfer), 64'(4 * int'(cnt)));
        check_val("ena_count", 64'(n_ena), 64'(cnt));
        check_val("done_pulses", 64'(n_done), 64'(1));
        check_val("idle_valid", 64'(out_valid), 64'(0));
        check_val("idle_busy", 64'(busy), 64'(0));
        if (cnt != 0) begin
            check_val("first_valid", 64'(first_v), 64'(2));
            check_val("done_latency", 64'(done_c), 64'(last_x + 1));
            if (mode == 0) check_val("no_bubble", 64'(last_x), 64'(first_v + 4 * int'(cnt) - 1));
        end else begin
            check_val("zero_done_lat", 64'(done_c), 64'(0));
            check_val("zero_no_valid", 64'(first_v), 64'(-1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {busy, done, ram_ena, out_valid, out_last, ram_addr, out_data}, 64'(0));
    endtask

    initial begin
        logic [15:0] b;
        logic [15:0] c;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0; out_ready = 1'b0;
        cyc = 0; junk_at = -1; mode_g = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;

        ram_mem[16'h0010] = 64'h0001_0002_0003_0004;
        ram_mem[16'h0011] = 64'h0005_0006_0007_0008;
        run(16'h0010, 16'd2, 0, 0);
        run(16'h0010, 16'd2, 1, 0);
        run(16'h0010, 16'd0, 0, 0);

        ram_mem[16'hFFFF] = 64'h1111_2222_3333_4444;
        ram_mem[16'h0000] = 64'h5555_6666_7777_0123;
        run(16'hFFFF, 16'd2, 0, 0);

        ram_mem[16'h0040] = 64'hFFFF_7FFF_8000_0001;
        run(16'h0040, 16'd1, 0, 0);

        for (int w = 0; w < 4; w++) ram_mem[16'h0020 + 16'(w)] = {$urandom, $urandom};
        run(16'h0020, 16'd4, 0, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_midrun");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        ram_mem[16'h0030] = 64'h0BAD_F00D_1234_ABCD;
        run(16'h0030, 16'd1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            b = ($urandom_range(0, 1) == 1) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            c = 16'($urandom_range(0, 6));
            for (int w = 0; w < int'(c); w++) ram_mem[b + 16'(w)] = {$urandom, $urandom};
            junk_at = (c != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : -1;
            run(b, c, int'($urandom_range(0, 2)), 0);
            junk_at = -1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
